// File: rtl/port_out_bank.sv
// Bank of NUM_PORTS memory-mapped output registers with set/clear/toggle aliases and update strobes.
// Optional PORT_OUT_SHADOW_EN: writes land in shadow registers and are committed to the ports together.
module port_out_bank #(
  parameter int WIDTH = 8,
  parameter int NUM_PORTS = 8,
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 8'hC0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       write,
  input  logic                       read,
  output logic [WIDTH-1:0]           data_out,
  output logic                       read_valid,
  output logic [NUM_PORTS*WIDTH-1:0] port_out,
  output logic [NUM_PORTS-1:0]       port_strobe
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_WIDTH:0] MAP_END = (ADDR_WIDTH+1)'(4 * NUM_PORTS);

  // One extra bit makes addresses below the base wrap to large offsets, i.e. unmapped.
  logic [ADDR_WIDTH:0] offset;
  logic                mapped;
  logic [IDX_W-1:0]    index;
  logic [1:0]          mode;

  assign offset = {1'b0, address} - {1'b0, BASE_ADDR};
  assign mapped = (offset < MAP_END);
  assign index  = IDX_W'(offset % NUM_PORTS);
  assign mode   = 2'(offset / NUM_PORTS);

`ifdef PORT_OUT_SHADOW_EN
  logic commit;
  assign commit = (offset == MAP_END);
`endif

  logic [WIDTH-1:0]     port_reg [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_strobe_reg;
  logic [WIDTH-1:0]     data_out_reg;
  logic                 read_valid_reg;

  function automatic logic [WIDTH-1:0] apply_mode(input logic [1:0] m,
                                                  input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] din);
    case (m)
      2'd0:    return din;
      2'd1:    return cur | din;
      2'd2:    return cur & ~din;
      default: return cur ^ din;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic hit;
      logic upd;
      assign hit = write && mapped && (index == IDX_W'(gi));

`ifdef PORT_OUT_SHADOW_EN
      logic [WIDTH-1:0] shadow_reg;
      assign upd = write && commit && data_in[gi];

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          shadow_reg <= '0;
        end else if (hit) begin
          shadow_reg <= apply_mode(mode, shadow_reg, data_in);
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          port_reg[gi] <= '0;
        end else if (upd) begin
          port_reg[gi] <= shadow_reg;
        end
      end
`else
      assign upd = hit;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          port_reg[gi] <= '0;
        end else if (upd) begin
          port_reg[gi] <= apply_mode(mode, port_reg[gi], data_in);
        end
      end
`endif

      // Strobe marks every accepted update, whether or not the value changed.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          port_strobe_reg[gi] <= 1'b0;
        end else begin
          port_strobe_reg[gi] <= upd;
        end
      end

      assign port_out[gi*WIDTH +: WIDTH] = port_reg[gi];
    end
  endgenerate

  // Read samples the pre-edge port value, so a same-cycle write is not visible.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out_reg   <= '0;
      read_valid_reg <= 1'b0;
    end else begin
      read_valid_reg <= read;
      if (read) begin
        data_out_reg <= mapped ? port_reg[index] : '0;
      end
    end
  end

  assign data_out    = data_out_reg;
  assign read_valid  = read_valid_reg;
  assign port_strobe = port_strobe_reg;

endmodule

// File: tb/tb_port_out_bank.sv
// Directed self-checking bench for port_out_bank (default 8 x 8-bit ports at 0xC0).
// Runs the shadow/commit scenario instead of the direct-write ones when PORT_OUT_SHADOW_EN is defined.
module tb_port_out_bank;

  logic        clock;
  logic        reset;
  logic [7:0]  address;
  logic [7:0]  data_in;
  logic        write;
  logic        read;
  logic [7:0]  data_out;
  logic        read_valid;
  logic [63:0] port_out;
  logic [7:0]  port_strobe;

  int checks = 0;
  int errors = 0;

  port_out_bank dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .data_in    (data_in),
    .write      (write),
    .read       (read),
    .data_out   (data_out),
    .read_valid (read_valid),
    .port_out   (port_out),
    .port_strobe(port_strobe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One bus cycle; returns 1 time unit after the edge so outputs reflect it.
  task automatic bus(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    write = w; read = r; address = a; data_in = d;
    @(posedge clock); #1;
    write = 1'b0; read = 1'b0;
    $display("bus w=%0b r=%0b addr=%h din=%h -> port_out=%h strobe=%b dout=%h valid=%b",
             w, r, a, d, port_out, port_strobe, data_out, read_valid);
  endtask

  task automatic test_reset;
    reset = 1'b1; write = 0; read = 0; address = 0; data_in = 0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (port_out !== 64'h0) begin errors++; $display("FAIL reset_port_out got %h exp %h", port_out, 64'h0); end
    checks++; if (port_strobe !== 8'h00) begin errors++; $display("FAIL reset_strobe got %h exp %h", port_strobe, 8'h00); end
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", read_valid); end
    reset = 1'b1;
    bus(0, 1, 8'hC3, 8'h00);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_read_data got %h exp 00", data_out); end
    checks++; if (read_valid !== 1'b1) begin errors++; $display("FAIL reset_read_valid got %b exp 1", read_valid); end
    checks++; if (port_out !== 64'h0) begin errors++; $display("FAIL reset_read_port_out got %h exp 0", port_out); end
  endtask

`ifndef PORT_OUT_SHADOW_EN
  task automatic test_direct;
    bus(1, 0, 8'hC2, 8'hA5);
    checks++; if (port_out !== 64'h0000_0000_00A5_0000) begin errors++; $display("FAIL direct_port_out got %h exp %h", port_out, 64'h0000_0000_00A5_0000); end
    checks++; if (port_strobe !== 8'b0000_0100) begin errors++; $display("FAIL direct_strobe got %b exp 00000100", port_strobe); end
    bus(0, 0, 8'h00, 8'h00);
    checks++; if (port_strobe !== 8'h00) begin errors++; $display("FAIL direct_strobe_drop got %b exp 0", port_strobe); end
  endtask

  task automatic test_alias;
    bus(1, 0, 8'hCA, 8'h0F);
    checks++; if (port_out[23:16] !== 8'hAF) begin errors++; $display("FAIL set_alias got %h exp AF", port_out[23:16]); end
    checks++; if (port_strobe !== 8'b0000_0100) begin errors++; $display("FAIL set_strobe got %b exp 00000100", port_strobe); end
    bus(1, 0, 8'hD2, 8'hA0);
    checks++; if (port_out[23:16] !== 8'h0F) begin errors++; $display("FAIL clear_alias got %h exp 0F", port_out[23:16]); end
    bus(1, 0, 8'hDA, 8'hFF);
    checks++; if (port_out[23:16] !== 8'hF0) begin errors++; $display("FAIL toggle_alias got %h exp F0", port_out[23:16]); end
    bus(0, 1, 8'hC2, 8'h00);
    checks++; if (data_out !== 8'hF0) begin errors++; $display("FAIL read_c2 got %h exp F0", data_out); end
    checks++; if (read_valid !== 1'b1) begin errors++; $display("FAIL read_c2_valid got %b exp 1", read_valid); end
    bus(0, 1, 8'hDA, 8'h00);
    checks++; if (data_out !== 8'hF0) begin errors++; $display("FAIL read_alias_da got %h exp F0", data_out); end
    bus(0, 0, 8'h00, 8'h00);
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", read_valid); end
    checks++; if (data_out !== 8'hF0) begin errors++; $display("FAIL idle_hold got %h exp F0", data_out); end
    checks++; if (port_out !== 64'h0000_0000_00F0_0000) begin errors++; $display("FAIL alias_others got %h exp %h", port_out, 64'h0000_0000_00F0_0000); end
  endtask

  task automatic test_unmapped;
    bus(1, 0, 8'hBF, 8'h55);
    checks++; if (port_out !== 64'h0000_0000_00F0_0000) begin errors++; $display("FAIL below_base_port got %h exp %h", port_out, 64'h0000_0000_00F0_0000); end
    checks++; if (port_strobe !== 8'h00) begin errors++; $display("FAIL below_base_strobe got %b exp 0", port_strobe); end
    bus(1, 0, 8'hE1, 8'h55);
    checks++; if (port_out !== 64'h0000_0000_00F0_0000) begin errors++; $display("FAIL e1_port got %h exp %h", port_out, 64'h0000_0000_00F0_0000); end
    checks++; if (port_strobe !== 8'h00) begin errors++; $display("FAIL e1_strobe got %b exp 0", port_strobe); end
    bus(1, 0, 8'hE0, 8'hFF);
    checks++; if (port_strobe !== 8'h00) begin errors++; $display("FAIL e0_strobe got %b exp 0", port_strobe); end
    bus(0, 1, 8'hE1, 8'h00);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL e1_read got %h exp 00", data_out); end
    checks++; if (read_valid !== 1'b1) begin errors++; $display("FAIL e1_read_valid got %b exp 1", read_valid); end
    // Rewriting the same value must still strobe.
    bus(1, 0, 8'hC2, 8'hF0);
    checks++; if (port_strobe !== 8'b0000_0100) begin errors++; $display("FAIL same_value_strobe got %b exp 00000100", port_strobe); end
  endtask

  task automatic test_same_cycle;
    bus(1, 0, 8'hC5, 8'h11);
    bus(1, 1, 8'hC5, 8'h33);
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL rw_pre_value got %h exp 11", data_out); end
    checks++; if (port_out[47:40] !== 8'h33) begin errors++; $display("FAIL rw_new_value got %h exp 33", port_out[47:40]); end
    checks++; if (port_strobe !== 8'b0010_0000) begin errors++; $display("FAIL rw_strobe got %b exp 00100000", port_strobe); end
  endtask

  task automatic test_back_to_back;
    bus(1, 0, 8'hC0, 8'h01);
    checks++; if (port_out[7:0] !== 8'h01) begin errors++; $display("FAIL b2b_write got %h exp 01", port_out[7:0]); end
    bus(1, 0, 8'hC8, 8'h02);
    checks++; if (port_out[7:0] !== 8'h03) begin errors++; $display("FAIL b2b_set got %h exp 03", port_out[7:0]); end
    bus(1, 0, 8'hD8, 8'h01);
    checks++; if (port_out[7:0] !== 8'h02) begin errors++; $display("FAIL b2b_toggle got %h exp 02", port_out[7:0]); end
    bus(1, 0, 8'hC7, 8'h77);
    checks++; if (port_strobe !== 8'b1000_0000) begin errors++; $display("FAIL b2b_strobe7 got %b exp 10000000", port_strobe); end
    bus(1, 0, 8'hC6, 8'h66);
    checks++; if (port_strobe !== 8'b0100_0000) begin errors++; $display("FAIL b2b_strobe6 got %b exp 01000000", port_strobe); end
    checks++; if (port_out !== 64'h7766_3300_00F0_0002) begin errors++; $display("FAIL b2b_all got %h exp %h", port_out, 64'h7766_3300_00F0_0002); end
  endtask

  task automatic test_async_reset;
    bus(1, 1, 8'hC1, 8'h5A);
    checks++; if (read_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", read_valid); end
    #2 reset = 1'b0;
    #1;
    $display("async reset asserted mid-cycle -> port_out=%h strobe=%b dout=%h valid=%b",
             port_out, port_strobe, data_out, read_valid);
    checks++; if (port_out !== 64'h0) begin errors++; $display("FAIL async_port_out got %h exp 0", port_out); end
    checks++; if (port_strobe !== 8'h00) begin errors++; $display("FAIL async_strobe got %b exp 0", port_strobe); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL async_data_out got %h exp 00", data_out); end
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", read_valid); end
    @(posedge clock); #2;
    reset = 1'b1;
    bus(1, 0, 8'hC1, 8'hAA);
    checks++; if (port_out !== 64'h0000_0000_0000_AA00) begin errors++; $display("FAIL first_write_after_reset got %h exp %h", port_out, 64'h0000_0000_0000_AA00); end
  endtask
`else
  task automatic test_shadow;
    bus(1, 0, 8'hC0, 8'h12);
    checks++; if (port_out !== 64'h0) begin errors++; $display("FAIL shadow_c0_port got %h exp 0", port_out); end
    checks++; if (port_strobe !== 8'h00) begin errors++; $display("FAIL shadow_c0_strobe got %b exp 0", port_strobe); end
    bus(1, 0, 8'hC1, 8'h34);
    checks++; if (port_out !== 64'h0) begin errors++; $display("FAIL shadow_c1_port got %h exp 0", port_out); end
    bus(1, 0, 8'hE0, 8'h01);
    checks++; if (port_out !== 64'h0000_0000_0000_0012) begin errors++; $display("FAIL commit0_port got %h exp %h", port_out, 64'h12); end
    checks++; if (port_strobe !== 8'b0000_0001) begin errors++; $display("FAIL commit0_strobe got %b exp 00000001", port_strobe); end
    bus(1, 0, 8'hE0, 8'h02);
    checks++; if (port_out !== 64'h0000_0000_0000_3412) begin errors++; $display("FAIL commit1_port got %h exp %h", port_out, 64'h3412); end
    checks++; if (port_strobe !== 8'b0000_0010) begin errors++; $display("FAIL commit1_strobe got %b exp 00000010", port_strobe); end
    bus(0, 1, 8'hE0, 8'h00);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL commit_read got %h exp 00", data_out); end
    bus(0, 1, 8'hC9, 8'h00);
    checks++; if (data_out !== 8'h34) begin errors++; $display("FAIL live_read got %h exp 34", data_out); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
`ifndef PORT_OUT_SHADOW_EN
    test_direct();
    test_alias();
    test_unmapped();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
`else
    test_shadow();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
